// File: rtl/ipsxb_fft_frame_ctrl.sv
// FFT input frame controller: post-reset hold-off, registered sample slice,
// per-frame tlast generation and zero-padding of flushed frames.
module ipsxb_fft_frame_ctrl #(
  parameter int LOG2_FFT_LEN = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int INIT_CYCLES  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_axi4s_data_tdata,
  input  logic                  i_axi4s_data_tvalid,
  output logic                  o_axi4s_data_tready,
  output logic [DATA_WIDTH-1:0] o_fft_data_tdata,
  output logic                  o_fft_data_tvalid,
  output logic                  o_fft_data_tlast,
  input  logic                  i_fft_data_tready,
  input  logic                  i_flush,
  output logic                  o_init_done,
  output logic                  o_pad_active,
  output logic [15:0]           o_frame_cnt
);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_RUN, S_PAD} state_t;

  localparam logic [LOG2_FFT_LEN-1:0] LAST_IDX  = {LOG2_FFT_LEN{1'b1}};
  localparam logic [15:0]             INIT_LAST = 16'(INIT_CYCLES - 1);

  state_t                  state;
  logic [LOG2_FFT_LEN-1:0] sample_cnt;
  logic [15:0]             init_cnt;
  logic                    slot_free;
  logic                    in_hs;
  logic                    last_idx;

  assign slot_free           = !o_fft_data_tvalid || i_fft_data_tready;
  assign o_axi4s_data_tready = ((state == S_IDLE) || (state == S_RUN)) && slot_free;
  assign in_hs               = i_axi4s_data_tvalid && o_axi4s_data_tready;
  assign last_idx            = (sample_cnt == LAST_IDX);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state             <= S_INIT;
      sample_cnt        <= '0;
      init_cnt          <= '0;
      o_fft_data_tdata  <= '0;
      o_fft_data_tvalid <= 1'b0;
      o_fft_data_tlast  <= 1'b0;
      o_init_done       <= 1'b0;
      o_pad_active      <= 1'b0;
      o_frame_cnt       <= '0;
    end else begin
      case (state)
        S_INIT: begin
          if (init_cnt == INIT_LAST) begin
            state       <= S_IDLE;
            o_init_done <= 1'b1;
          end else begin
            init_cnt <= init_cnt + 16'd1;
          end
        end

        S_IDLE: begin
          // Flush is meaningless between frames and is ignored here.
          if (in_hs) begin
            o_fft_data_tdata  <= i_axi4s_data_tdata;
            o_fft_data_tvalid <= 1'b1;
            o_fft_data_tlast  <= 1'b0;
            sample_cnt        <= sample_cnt + 1'b1;
            state             <= S_RUN;
          end else if (slot_free) begin
            o_fft_data_tvalid <= 1'b0;
            o_fft_data_tlast  <= 1'b0;
          end
        end

        S_RUN: begin
          if (in_hs) begin
            o_fft_data_tdata  <= i_axi4s_data_tdata;
            o_fft_data_tvalid <= 1'b1;
            o_fft_data_tlast  <= last_idx;
            if (last_idx) begin
              // A flush on the final sample is absorbed by normal completion.
              sample_cnt  <= '0;
              o_frame_cnt <= o_frame_cnt + 16'd1;
              state       <= S_IDLE;
            end else begin
              sample_cnt <= sample_cnt + 1'b1;
              if (i_flush) begin
                state        <= S_PAD;
                o_pad_active <= 1'b1;
              end
            end
          end else begin
            if (slot_free) begin
              o_fft_data_tvalid <= 1'b0;
              o_fft_data_tlast  <= 1'b0;
            end
            if (i_flush) begin
              state        <= S_PAD;
              o_pad_active <= 1'b1;
            end
          end
        end

        S_PAD: begin
          if (slot_free) begin
            o_fft_data_tdata  <= '0;
            o_fft_data_tvalid <= 1'b1;
            o_fft_data_tlast  <= last_idx;
            if (last_idx) begin
              sample_cnt   <= '0;
              o_frame_cnt  <= o_frame_cnt + 16'd1;
              o_pad_active <= 1'b0;
              state        <= S_IDLE;
            end else begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end
        end

        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_ipsxb_fft_frame_ctrl.sv
// Directed bench for ipsxb_fft_frame_ctrl with 8-sample frames and a 16-clock init window.
module tb_ipsxb_fft_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_dat;
  logic        in_vld;
  logic        in_rdy;
  logic [31:0] out_dat;
  logic        out_vld;
  logic        out_lst;
  logic        sink_rdy;
  logic        flush;
  logic        init_done;
  logic        pad_active;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ipsxb_fft_frame_ctrl #(
    .LOG2_FFT_LEN(3),
    .DATA_WIDTH  (32),
    .INIT_CYCLES (16)
  ) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_axi4s_data_tdata  (in_dat),
    .i_axi4s_data_tvalid (in_vld),
    .o_axi4s_data_tready (in_rdy),
    .o_fft_data_tdata    (out_dat),
    .o_fft_data_tvalid   (out_vld),
    .o_fft_data_tlast    (out_lst),
    .i_fft_data_tready   (sink_rdy),
    .i_flush             (flush),
    .o_init_done         (init_done),
    .o_pad_active        (pad_active),
    .o_frame_cnt         (frame_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives n back-to-back samples base..base+n-1 and checks each one a cycle later.
  task automatic send_seq(input int base, input int n, input int pos0, input bit flush_last);
    for (int i = 0; i < n; i++) begin
      in_vld = 1'b1;
      in_dat = 32'(base + i);
      flush  = flush_last && (i == n - 1);
      #1;
      chk("in_rdy", {31'd0, in_rdy}, 32'd1);
      @(negedge clk);
      chk("out_dat", out_dat, 32'(base + i));
      chk("out_vld", {31'd0, out_vld}, 32'd1);
      chk("out_lst", {31'd0, out_lst}, {31'd0, ((pos0 + i) % 8) == 7});
    end
    in_vld = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic drain();
    @(negedge clk);
    #1;
    chk("drained_vld", {31'd0, out_vld}, 32'd0);
  endtask

  initial begin
    int consumed;
    int sent;
    int cyc;
    bit held;
    logic [31:0] held_dat;
    logic held_lst;

    rst = 1'b1; in_dat = '0; in_vld = 1'b0; sink_rdy = 1'b1; flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_vld", {31'd0, out_vld}, 32'd0);
    chk("rst_lst", {31'd0, out_lst}, 32'd0);
    chk("rst_dat", out_dat, 32'd0);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_pad", {31'd0, pad_active}, 32'd0);
    chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);

    // Init window: ready only once 16 clocks have elapsed with reset low.
    rst = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk("init_rdy", {31'd0, in_rdy}, {31'd0, k == 16});
      chk("init_done", {31'd0, init_done}, {31'd0, k == 16});
    end

    // Three back-to-back frames.
    send_seq(1, 24, 0, 1'b0);
    chk("frame_cnt_3", {16'd0, frame_cnt}, 32'd3);
    drain();

    // Random sink backpressure: stream 100..115, checking order, stalls and tlast.
    consumed = 0; sent = 0; cyc = 0; held = 1'b0; held_dat = '0; held_lst = 1'b0;
    while (consumed < 16 && cyc < 400) begin
      if (held) begin
        chk("stall_vld", {31'd0, out_vld}, 32'd1);
        chk("stall_dat", out_dat, held_dat);
        chk("stall_lst", {31'd0, out_lst}, {31'd0, held_lst});
      end
      sink_rdy = 1'($urandom_range(0, 1));
      in_vld   = (sent < 16);
      in_dat   = 32'(100 + sent);
      #1;
      if (out_vld) chk("stall_in_rdy", {31'd0, in_rdy}, {31'd0, sink_rdy});
      held = 1'b0;
      if (out_vld && sink_rdy) begin
        chk("rnd_dat", out_dat, 32'(100 + consumed));
        chk("rnd_lst", {31'd0, out_lst}, {31'd0, (consumed % 8) == 7});
        consumed++;
      end else if (out_vld) begin
        held = 1'b1; held_dat = out_dat; held_lst = out_lst;
      end
      if (in_vld && in_rdy) sent++;
      @(negedge clk);
      cyc++;
    end
    chk("rnd_consumed", 32'(consumed), 32'd16);
    in_vld = 1'b0; sink_rdy = 1'b1;
    #1;
    chk("frame_cnt_5", {16'd0, frame_cnt}, 32'd5);
    drain();

    // Flush after three samples: five zeros, last one tagged.
    send_seq(5, 3, 0, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_vld = 1'b1; in_dat = 32'hDEAD;
    chk("pad_gap_vld", {31'd0, out_vld}, 32'd0);
    for (int p = 0; p < 5; p++) begin
      #1;
      chk("pad_active", {31'd0, pad_active}, 32'd1);
      chk("pad_in_rdy", {31'd0, in_rdy}, 32'd0);
      if (p > 0) begin
        chk("pad_dat", out_dat, 32'd0);
        chk("pad_vld", {31'd0, out_vld}, 32'd1);
        chk("pad_lst", {31'd0, out_lst}, 32'd0);
      end
      @(negedge clk);
    end
    in_vld = 1'b0;
    #1;
    chk("pad_end_dat", out_dat, 32'd0);
    chk("pad_end_vld", {31'd0, out_vld}, 32'd1);
    chk("pad_end_lst", {31'd0, out_lst}, 32'd1);
    chk("pad_end_active", {31'd0, pad_active}, 32'd0);
    chk("pad_end_in_rdy", {31'd0, in_rdy}, 32'd1);
    chk("frame_cnt_6", {16'd0, frame_cnt}, 32'd6);
    drain();

    // Flush on the 8th sample completes the frame normally.
    send_seq(11, 8, 0, 1'b1);
    chk("coinc_pad", {31'd0, pad_active}, 32'd0);
    chk("frame_cnt_7", {16'd0, frame_cnt}, 32'd7);
    drain();
    chk("coinc_pad_after", {31'd0, pad_active}, 32'd0);

    // Flush while idle does nothing.
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("idle_flush_pad", {31'd0, pad_active}, 32'd0);
    chk("idle_flush_vld", {31'd0, out_vld}, 32'd0);
    chk("idle_flush_rdy", {31'd0, in_rdy}, 32'd1);
    send_seq(21, 8, 0, 1'b0);
    chk("frame_cnt_8", {16'd0, frame_cnt}, 32'd8);

    // Reset mid-frame discards the partial frame and repeats init.
    drain();
    send_seq(31, 4, 0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_vld", {31'd0, out_vld}, 32'd0);
    chk("mid_rst_lst", {31'd0, out_lst}, 32'd0);
    chk("mid_rst_dat", out_dat, 32'd0);
    chk("mid_rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    chk("mid_rst_init_done", {31'd0, init_done}, 32'd0);
    chk("mid_rst_in_rdy", {31'd0, in_rdy}, 32'd0);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      #1;
      chk("reinit_rdy", {31'd0, in_rdy}, {31'd0, k == 16});
    end
    send_seq(41, 8, 0, 1'b0);
    chk("frame_cnt_1", {16'd0, frame_cnt}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
